// File: rtl/alu_pipe.sv
// Handshaked 8-bit ALU responder: one combinational op stage feeding a result
// register backed by a single skid entry, so downstream stalls never drop requests.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [15:0]      op_count
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } res_t;

  res_t           res;
  res_t           out_q;
  res_t           skid_q;
  logic           out_v;
  logic           skid_v;
  logic [15:0]    cnt;
  logic           in_xfer;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] prod;

  assign sh = b[SHW-1:0];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    wide = '0;
    dbl  = '0;
    prod = '0;
    res  = '0;
    case (aluop)
      4'd0: begin
        wide  = {1'b0, a} + {1'b0, b};
        res.o = wide[MSB:0];
        res.c = wide[WIDTH];
        res.v = (a[MSB] == b[MSB]) && (res.o[MSB] != a[MSB]);
      end
      4'd1: begin
        wide  = {1'b0, a} - {1'b0, b};
        res.o = wide[MSB:0];
        res.c = wide[WIDTH];
        res.v = (a[MSB] != b[MSB]) && (res.o[MSB] != a[MSB]);
      end
      4'd2: res.o = a & b;
      4'd3: res.o = a | b;
      4'd4: res.o = a ^ b;
      4'd5: res.o = ~a;
      4'd6: begin
        // The extra top bit catches the last bit shifted out; it stays 0 for sh == 0.
        wide  = {1'b0, a} << sh;
        res.o = wide[MSB:0];
        res.c = wide[WIDTH];
      end
      4'd7: begin
        wide  = {a, 1'b0} >> sh;
        res.o = wide[WIDTH:1];
        res.c = wide[0];
      end
      4'd8: res.o = $signed(a) >>> sh;
      4'd9: begin
        dbl   = {a, a} << sh;
        res.o = dbl[2*WIDTH-1:WIDTH];
      end
      4'd10: begin
        dbl   = {a, a} >> sh;
        res.o = dbl[MSB:0];
      end
      4'd11: begin
        wide  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        res.o = wide[MSB:0];
        res.c = wide[WIDTH];
        res.v = !a[MSB] && res.o[MSB];
      end
      4'd12: begin
        wide  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        res.o = wide[MSB:0];
        res.c = wide[WIDTH];
        res.v = a[MSB] && !res.o[MSB];
      end
      4'd13: begin
        prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        res.o = prod[MSB:0];
        res.c = |prod[2*WIDTH-1:WIDTH];
      end
      4'd14: res.o = {{(WIDTH-1){1'b0}}, a < b};
      4'd15: res.o = b;
    endcase
    res.z = ~|res.o;
    res.n = res.o[MSB];
  end

  assign in_ready = !skid_v;
  assign in_xfer  = in_valid && in_ready;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      cnt    <= '0;
    end else begin
      if (in_xfer) cnt <= cnt + 16'd1;
      if (!out_v || out_ready) begin
        // Output register is free or draining: the skid has priority to keep order.
        if (skid_v) begin
          out_q  <= skid_q;
          out_v  <= 1'b1;
          skid_v <= 1'b0;
        end else if (in_xfer) begin
          out_q <= res;
          out_v <= 1'b1;
        end else begin
          out_v <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q <= res;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid = out_v;
  assign o         = out_q.o;
  assign flag_z    = out_q.z;
  assign flag_n    = out_q.n;
  assign flag_c    = out_q.c;
  assign flag_v    = out_q.v;
  assign op_count  = cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized self-checking bench for alu_pipe: reset, op sweep,
// flag corners, backpressure through the skid entry, reset mid-stall, random stream.
module tb_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  aluop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  o;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam int N_RAND    = 10000;
  localparam int MAX_CYCLE = 60000;

  logic [7:0] exp_sweep [16] = '{8'd66, 8'd62, 8'd0, 8'd66, 8'd66, 8'd191, 8'd0, 8'd16,
                                 8'd16, 8'd1, 8'd16, 8'd65, 8'd63, 8'd128, 8'd0, 8'd2};

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent integer model: returns {o, z, n, c, v}.
  function automatic logic [11:0] ref_alu(input int ua, input int ub, input int op);
    int   r;
    int   sa;
    int   sb;
    int   sh;
    logic c;
    logic v;
    sh = ub % 8;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      0:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1:  begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  r = 255 - ua;
      6:  begin r = ua << sh; c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1); end
      7:  begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      8:  r = sa >>> sh;
      9:  r = (ua << sh) | (ua >> (8 - sh));
      10: r = (ua >> sh) | (ua << (8 - sh));
      11: begin r = ua + 1; c = (ua == 255); v = (ua == 127); end
      12: begin r = ua - 1; c = (ua == 0); v = (ua == 128); end
      13: begin r = ua * ub; c = (r > 255); end
      14: r = (ua < ub) ? 1 : 0;
      15: r = ub;
      default: r = 0;
    endcase
    r = r & 255;
    return {r[7:0], r == 0, r[7], c, v};
  endfunction

  initial begin
    int          sent;
    int          cycles;
    logic [11:0] q[$];
    logic [11:0] held;
    logic [11:0] front;
    logic        stalled;

    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'd9;
    b         = 8'd9;
    aluop     = 4'd0;
    out_ready = 1'b1;
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_o", o, 0);
    check("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Op sweep, a=64, b=2, one result per cycle with out_ready high.
    a = 8'd64;
    b = 8'd2;
    for (int i = 0; i < 16; i++) begin
      aluop    = 4'(i);
      in_valid = 1'b1;
      check("sweep_in_ready", in_ready, 1);
      step();
      check($sformatf("sweep_valid_%0d", i), out_valid, 1);
      check($sformatf("sweep_o_%0d", i), o, exp_sweep[i]);
      check($sformatf("sweep_c_%0d", i), flag_c, (i == 6) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("sweep_op_count", op_count, 16);
    step();
    check("sweep_idle", out_valid, 0);

    // Flag corners: {o, z, n, c, v}.
    in_valid = 1'b1;
    a = 8'd127; b = 8'd1; aluop = 4'd0;
    step();
    check("flag_add_ovf", {o, flag_z, flag_n, flag_c, flag_v}, {8'd128, 4'b0101});
    a = 8'd255; b = 8'd1; aluop = 4'd0;
    step();
    check("flag_add_carry", {o, flag_z, flag_n, flag_c, flag_v}, {8'd0, 4'b1010});
    a = 8'd0; b = 8'd1; aluop = 4'd12;
    step();
    check("flag_dec_borrow", {o, flag_z, flag_n, flag_c, flag_v}, {8'd255, 4'b0110});
    in_valid = 1'b0;
    step();
    check("flag_op_count", op_count, 19);

    // Backpressure: two requests fill register and skid, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'd10; b = 8'd3; aluop = 4'd0;
    step();
    check("bp_first_o", o, 13);
    check("bp_first_ready", in_ready, 1);
    aluop = 4'd1;
    step();
    check("bp_skid_full", in_ready, 0);
    check("bp_hold_o1", o, 13);
    aluop = 4'd2;
    step();
    check("bp_third_blocked", in_ready, 0);
    check("bp_hold_o2", {out_valid, o}, {1'b1, 8'd13});
    check("bp_op_count", op_count, 21);
    out_ready = 1'b1;
    step();
    check("bp_drain_o", {out_valid, o}, {1'b1, 8'd7});
    check("bp_ready_back", in_ready, 1);
    check("bp_count_hold", op_count, 21);
    step();
    check("bp_third_o", {out_valid, o}, {1'b1, 8'd2});
    check("bp_third_count", op_count, 22);
    in_valid = 1'b0;
    step();
    check("bp_idle", out_valid, 0);

    // Reset with both entries occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluop = 4'd15; b = 8'h55;
    step();
    b = 8'hAA;
    step();
    check("rs_full", {in_ready, out_valid, o}, {1'b0, 1'b1, 8'h55});
    rst = 1'b1;
    b   = 8'h11;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rs_out_valid", out_valid, 0);
    check("rs_o_flags", {o, flag_z, flag_n, flag_c, flag_v}, 0);
    check("rs_op_count", op_count, 0);
    check("rs_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rs_no_stale", out_valid, 0);
    end

    // Random stream against the integer model.
    sent   = 0;
    cycles = 0;
    while ((sent < N_RAND || q.size() != 0) && cycles < MAX_CYCLE) begin
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      aluop     = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          front = q.pop_front();
          check("rand_out", {o, flag_z, flag_n, flag_c, flag_v}, front);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_alu(int'(a), int'(b), int'(aluop)));
        sent++;
      end
      stalled = out_valid && !out_ready;
      held    = {o, flag_z, flag_n, flag_c, flag_v};
      step();
      cycles++;
      if (stalled) check("rand_stall_hold", {out_valid, o, flag_z, flag_n, flag_c, flag_v}, {1'b1, held});
    end
    in_valid = 1'b0;
    check("rand_sent", sent, N_RAND);
    check("rand_drained", q.size(), 0);
    check("rand_op_count", op_count, 16'(N_RAND));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
